inst_mem_loadable: RTL

Parametrised, run-time loadable instruction memory; successor to the fixed combinational instruction ROM. Serves the processor's fetch stage with a registered 1-cycle read. Accepts a streamed program image through a valid/ready load port, so programs change without resynthesis. Unwritten or out-of-range locations return the HALT encoding, so a stray PC halts the core.

---
 rtl/inst_mem_if.sv | 20 ++
 rtl/inst_mem_loadable.sv | 68 ++++++
 2 files changed

// File: rtl/inst_mem_if.sv
// inst_mem_if: fetch and program-load bus of the loadable instruction memory
interface inst_mem_if #(parameter int INST_WIDTH = 10, parameter int ADDR_WIDTH = 16, parameter int DEPTH = 32);
  localparam int CW = $clog2(DEPTH + 1);
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [INST_WIDTH-1:0] inst_out;
  logic                  inst_valid;
  logic                  load_start;
  logic                  load_valid;
  logic [INST_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  load_done;
  logic [CW-1:0]         load_count;
  logic                  busy;
  modport master (output fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
                  input inst_out, inst_valid, load_ready, load_done, load_count, busy);
  modport slave  (input fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
                  output inst_out, inst_valid, load_ready, load_done, load_count, busy);
endinterface

// File: rtl/inst_mem_loadable.sv
// inst_mem_loadable: run-time loadable instruction memory with registered fetch; unwritten words read HALT
module inst_mem_loadable #(
  parameter int INST_WIDTH = 10,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH = 32,
  parameter logic [INST_WIDTH-1:0] HALT_WORD = INST_WIDTH'(10'b1110000000)
) (
  input logic clk,
  input logic rst_n,
  inst_mem_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2;
  logic [1:0]            state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DEPTH-1:0]      written_q, written_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  valid_q, valid_d;
  logic [INST_WIDTH-1:0] mem [DEPTH];
  logic                  start, xfer, fetch_ok, hit;
  logic [PW-1:0]         idx;
  assign idx      = bus.fetch_addr[PW-1:0];
  assign start    = state_q == IDLE && bus.load_start;
  assign xfer     = state_q == LOAD && bus.load_valid;
  assign fetch_ok = state_q == IDLE && bus.fetch_req && !bus.load_start;
  // idx is only meaningful once the full-width range check has passed
  assign hit      = ({1'b0, bus.fetch_addr} < LIMIT) && written_q[idx];
  always_comb begin
    state_d   = start ? LOAD
              : xfer && (bus.load_last || ptr_q == PW'(DEPTH - 1)) ? DONE
              : state_q == DONE ? IDLE : state_q;
    ptr_d     = start ? '0 : xfer ? ptr_q + PW'(1) : ptr_q;
    cnt_d     = start ? '0 : xfer ? cnt_q + CW'(1) : cnt_q;
    written_d = start ? '0 : written_q;
    if (xfer) written_d[ptr_q] = 1'b1;
    valid_d   = fetch_ok;
    inst_d    = fetch_ok ? (hit ? mem[idx] : HALT_WORD) : inst_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      written_q <= '0;
      inst_q    <= HALT_WORD;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      written_q <= written_d;
      inst_q    <= inst_d;
      valid_q   <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (xfer) mem[ptr_q] <= bus.load_data;
  end
  assign bus.inst_out   = inst_q;
  assign bus.inst_valid = valid_q;
  assign bus.load_ready = state_q == LOAD;
  assign bus.load_done  = state_q == DONE;
  assign bus.load_count = cnt_q;
  assign bus.busy       = state_q != IDLE;
endmodule
